pixel_frame_assembler: RTL and testbench

- Upstream neighbour of median_filter. Collects a raster-order pixel stream (camera/UART capture path) into one packed R_I x C_I x W_I image and presents it on `img`.
- median_filter consumes `img` directly.
- Valid/ready handshake on the input and output sides, so stream producer and filter pipeline are decoupled.

---
 rtl/img_pkg.sv | 22 ++
 rtl/pixel_frame_assembler_raster_counter.sv | 49 ++++
 rtl/pixel_frame_assembler.sv | 172 +++++++++++++++++
 tb/tb_pixel_frame_assembler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Types and default geometry shared by the pixel assembler, median_filter and their benches.
package img_pkg;

    localparam int unsigned R_I = 5;
    localparam int unsigned C_I = 5;
    localparam int unsigned W_I = 8;

    typedef logic unsigned [W_I-1:0] pixel_t;
    typedef pixel_t [R_I-1:0][C_I-1:0] img_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL
    } fsm_state_t;

    // Counter width for n positions; a single position still needs one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_frame_assembler_raster_counter.sv
// Row-major raster position counter: reports the position the current beat writes
// (forced to [0][0] on restart) and steps to the following position when enabled.
module raster_counter
    import img_pkg::*;
#(
    parameter int unsigned ROWS = 5,
    parameter int unsigned COLS = 5,
    localparam int unsigned RW = cnt_w(ROWS),
    localparam int unsigned CW = cnt_w(COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          restart,
    output logic [RW-1:0] pos_row,
    output logic [CW-1:0] pos_col,
    output logic          pos_last
);

    logic [RW-1:0] row;
    logic [RW-1:0] row_nxt;
    logic [CW-1:0] col;
    logic [CW-1:0] col_nxt;

    always_comb begin
        pos_row  = restart ? '0 : row;
        pos_col  = restart ? '0 : col;
        pos_last = (pos_row == RW'(ROWS - 1)) && (pos_col == CW'(COLS - 1));
        row_nxt  = pos_row;
        col_nxt  = pos_col;
        if (pos_col == CW'(COLS - 1)) begin
            col_nxt = '0;
            row_nxt = (pos_row == RW'(ROWS - 1)) ? '0 : pos_row + RW'(1);
        end else begin
            col_nxt = pos_col + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            row <= row_nxt;
            col <= col_nxt;
        end
    end

endmodule

// File: rtl/pixel_frame_assembler.sv
// Collects a raster pixel stream into one packed R_I x C_I image for median_filter.
// Define PIXEL_FRAME_ASSEMBLER_DOUBLE_BUFFER_EN for ping-pong banks; default is a single bank.
module pixel_frame_assembler #(
    parameter int unsigned R_I = img_pkg::R_I,
    parameter int unsigned C_I = img_pkg::C_I,
    parameter int unsigned W_I = img_pkg::W_I
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [W_I-1:0]                     s_data,
    input  logic                               s_sof,
    output logic                               img_valid,
    input  logic                               img_ready,
    output logic [R_I-1:0][C_I-1:0][W_I-1:0]   img,
    output logic                               err_sof
);
    import img_pkg::*;

    localparam int unsigned RW = cnt_w(R_I);
    localparam int unsigned CW = cnt_w(C_I);

    fsm_state_t    state;
    fsm_state_t    state_nxt;
    logic          alive;
    logic          xfer;
    logic          out_xfer;
    logic          wr_en;
    logic          idle_like;
    logic          err_nxt;
    logic [RW-1:0] pos_row;
    logic [CW-1:0] pos_col;
    logic          pos_last;

    assign xfer     = s_valid && s_ready;
    assign out_xfer = img_valid && img_ready;
    assign wr_en    = xfer && (s_sof || (state == FILL));
    assign err_nxt  = xfer && ((idle_like && !s_sof) || ((state == FILL) && s_sof));

    raster_counter #(
        .ROWS (R_I),
        .COLS (C_I)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (wr_en),
        .restart  (s_sof),
        .pos_row  (pos_row),
        .pos_col  (pos_col),
        .pos_last (pos_last)
    );

    // alive keeps s_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive   <= 1'b0;
            err_sof <= 1'b0;
        end else begin
            alive   <= 1'b1;
            err_sof <= err_nxt;
        end
    end

`ifdef PIXEL_FRAME_ASSEMBLER_DOUBLE_BUFFER_EN

    logic [1:0][R_I-1:0][C_I-1:0][W_I-1:0] bank;
    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       wr_sel;
    logic       wr_sel_nxt;
    logic       rd_sel;
    logic       wbank;
    logic       complete;

    // In FULL both banks hold frames and the read bank is the other one; an
    // accepted pixel there lands in the read bank as it is consumed this edge.
    assign idle_like = (state == IDLE) || (state == FULL);
    assign wbank     = (state == FULL) ? !wr_sel : wr_sel;
    assign complete  = wr_en && pos_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            state  <= state_nxt;
            full   <= full_nxt;
            wr_sel <= wr_sel_nxt;
            rd_sel <= out_xfer ? !rd_sel : rd_sel;
        end
    end

    always_comb begin
        full_nxt = full;
        if (out_xfer) begin
            full_nxt[rd_sel] = 1'b0;
        end
        if (complete) begin
            full_nxt[wbank] = 1'b1;
        end
        wr_sel_nxt = (full_nxt[wr_sel] && !full_nxt[!wr_sel]) ? !wr_sel : wr_sel;
        if (full_nxt[wr_sel_nxt]) begin
            state_nxt = FULL;
        end else if (complete) begin
            state_nxt = IDLE;
        end else if (wr_en) begin
            state_nxt = FILL;
        end else if (state == FULL) begin
            state_nxt = IDLE;
        end else begin
            state_nxt = state;
        end
    end

    always_comb begin
        s_ready   = alive && ((state != FULL) || img_ready);
        img_valid = full[rd_sel];
        img       = bank[rd_sel];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank <= '0;
        end else if (wr_en) begin
            bank[wbank][pos_row][pos_col] <= s_data;
        end
    end

`else

    logic [R_I-1:0][C_I-1:0][W_I-1:0] frame;

    assign idle_like = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer && s_sof) state_nxt = pos_last ? FULL : FILL;
            FILL:    if (xfer && pos_last) state_nxt = FULL;
            FULL:    if (out_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready   = alive && (state != FULL);
        img_valid = (state == FULL);
        img       = frame;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame <= '0;
        end else if (wr_en) begin
            frame[pos_row][pos_col] <= s_data;
        end
    end

`endif

endmodule

// File: tb/tb_pixel_frame_assembler.sv
// Scoreboard bench for pixel_frame_assembler: a stream model pushes completed frames,
// a monitor pops and compares them when the DUT hands a frame over.
module tb_pixel_frame_assembler;
    import img_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    logic   s_valid;
    logic   s_ready;
    pixel_t s_data;
    logic   s_sof;
    logic   img_valid;
    logic   img_ready;
    img_t   img;
    logic   err_sof;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned exp_err  = 0;
    int unsigned err_seen = 0;
    int unsigned pushed   = 0;
    int unsigned popped   = 0;
    int unsigned retries  = 0;

    img_t sb[$];
    img_t m_img;
    int   m_k    = 0;
    bit   m_fill = 1'b0;

    always #5 clk = ~clk;

    pixel_frame_assembler #(
        .R_I (R_I),
        .C_I (C_I),
        .W_I (W_I)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_sof     (s_sof),
        .img_valid (img_valid),
        .img_ready (img_ready),
        .img       (img),
        .err_sof   (err_sof)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Stream-side reference: row-major fill, sof restarts, stray pixels discarded.
    task automatic model_accept(input pixel_t d, input logic sof);
        if (!m_fill && !sof) begin
            exp_err++;
        end else begin
            if (sof) begin
                if (m_fill) exp_err++;
                m_k = 0;
            end
            m_img[m_k / C_I][m_k % C_I] = d;
            m_k++;
            m_fill = 1'b1;
            if (m_k == R_I * C_I) begin
                sb.push_back(m_img);
                pushed++;
                m_fill = 1'b0;
            end
        end
    endtask

    task automatic send_pix(input pixel_t d, input logic sof);
        bit done = 1'b0;
        for (int unsigned t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = d;
            s_sof   = sof;
            #4;
            done = s_ready;
            if (!done) retries++;
            @(posedge clk);
        end
        #1;
        s_valid = 1'b0;
        if (done) model_accept(d, sof);
        else check("send_timeout", 0, 1);
    endtask

    task automatic send_frame(input int unsigned base, input bit rnd_data, input bit gaps);
        pixel_t d;
        for (int unsigned i = 0; i < R_I * C_I; i++) begin
            if (gaps && ($urandom_range(1) == 1)) @(posedge clk);
            d = rnd_data ? pixel_t'($urandom_range(255)) : pixel_t'(base + i);
            send_pix(d, i == 0);
        end
    endtask

    task automatic check_err(input string tag);
        repeat (2) @(posedge clk);
        #1;
        check(tag, err_seen, exp_err);
    endtask

    // Monitor: samples one time unit before each rising edge.
    bit   pv    = 1'b0;
    bit   ptake = 1'b0;
    img_t pimg;
    img_t exp_img;
    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (err_sof) err_seen++;
            if (img_valid && pv && !ptake) check("img_hold", img, pimg);
            if (img_valid && img_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    exp_img = sb.pop_front();
                    popped++;
                    check("frame", img, exp_img);
                end
            end
            pv    = img_valid;
            pimg  = img;
            ptake = img_valid && img_ready;
        end
    end

    initial begin
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        s_sof     = 1'b0;
        img_ready = 1'b0;
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_img_valid", img_valid, 0);
        check("rst_err", err_sof, 0);
        check("rst_img", img, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_s_ready_low", s_ready, 0);
        @(posedge clk);
        #1;
        check("rel_s_ready_high", s_ready, 1);

        // Frame 0..24, consumer stalled.
        send_frame(0, 1'b0, 1'b0);
        check("latency_valid", img_valid, 1);
`ifndef PIXEL_FRAME_ASSEMBLER_DOUBLE_BUFFER_EN
        check("full_s_ready", s_ready, 0);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        img_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drop_valid", img_valid, 0);
        check("idle_ready", s_ready, 1);
        @(negedge clk);
        img_ready = 1'b0;

        // Same frame with random gaps, consumer held off 10 cycles.
        send_frame(0, 1'b0, 1'b1);
        repeat (10) begin
            @(posedge clk);
            #1;
            check("hold_valid", img_valid, 1);
        end
        @(negedge clk);
        img_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drop_valid2", img_valid, 0);
        check_err("err_none");

        // Stray pixels in IDLE, then a frame.
        for (int unsigned i = 0; i < 3; i++) send_pix(pixel_t'(8'h11 + i), 1'b0);
        send_frame(0, 1'b1, 1'b0);
        check_err("err_stray");

        // Restart mid-frame at pixel 7.
        for (int unsigned i = 0; i < 7; i++) send_pix(pixel_t'(i), i == 0);
        send_pix(8'hAA, 1'b1);
        for (int unsigned i = 1; i < R_I * C_I; i++) send_pix(pixel_t'(100 + i), 1'b0);
        check("restart_latency", img_valid, 1);
        check_err("err_restart");

        // Asynchronous reset mid-frame.
        for (int unsigned i = 0; i < 13; i++) send_pix(pixel_t'(50 + i), i == 0);
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", img_valid, 0);
        check("arst_ready", s_ready, 0);
        check("arst_err", err_sof, 0);
        check("arst_img", img, 0);
        m_fill = 1'b0;
        m_k    = 0;
        @(negedge clk);
        rst = 1'b0;
        send_frame(0, 1'b1, 1'b0);
        check_err("err_after_rst");

        // Random frames, consumer always ready.
        for (int unsigned f = 0; f < 100; f++) send_frame(0, 1'b1, f[0]);

`ifdef PIXEL_FRAME_ASSEMBLER_DOUBLE_BUFFER_EN
        retries = 0;
        send_frame(0, 1'b1, 1'b0);
        send_frame(0, 1'b1, 1'b0);
        check("b2b_no_gap", retries, 0);
`endif

        for (int unsigned t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
        check_err("err_final");
        check("sb_drained", sb.size(), 0);
        check("frames_popped", popped, pushed);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
